// File: rtl/clk_div_pkg.sv
// Shared definitions for the multi-channel clock divider: channel FSM
// states and the default channel count / ratio width.
package clk_div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HIGH   = 2'd1,
        ST_LOW    = 2'd2,
        ST_BYPASS = 2'd3
    } ch_state_t;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_DIV_W  = 8;

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: FSM (IDLE/HIGH/LOW/BYPASS), a phase counter that
// counts down the cycles left in the current phase, and the ratio that is
// latched for the running period. Ratios below 2 pass clk straight through.
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int DIV_W = DEF_DIV_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [DIV_W-1:0] div,
    input  logic             sync,
    output logic             clk_out,
    output logic             tick,
    output logic             active
);

    ch_state_t        state_reg;
    logic [DIV_W-1:0] cnt_reg;
    logic [DIV_W-1:0] act_div_reg;
    logic             clk_reg;
    logic             tick_reg;

    logic             div_ok;
    logic             period_end;
    logic             load_req;
    logic             idle_req;

    // Last count value of the high phase: ceil(d/2)-1, computed without
    // widening so that the largest ratio still fits in DIV_W bits.
    function automatic logic [DIV_W-1:0] high_last(input logic [DIV_W-1:0] d);
        return (d >> 1) + {{(DIV_W-1){1'b0}}, d[0]} - DIV_W'(1);
    endfunction

    // Last count value of the low phase: floor(d/2)-1.
    function automatic logic [DIV_W-1:0] low_last(input logic [DIV_W-1:0] d);
        return (d >> 1) - DIV_W'(1);
    endfunction

    // Decode which transition the next edge takes; sync outranks the
    // period-boundary decision, and a new ratio is only ever taken on a load.
    always_comb begin
        div_ok     = (div >= DIV_W'(2));
        period_end = (state_reg == ST_LOW) && (cnt_reg == '0);
        load_req   = 1'b0;
        idle_req   = 1'b0;
        unique case (state_reg)
            ST_IDLE:   load_req = enable;
            ST_HIGH:   load_req = sync;
            ST_LOW: begin
                load_req = sync || (period_end && enable);
                idle_req = !sync && period_end && !enable;
            end
            ST_BYPASS: begin
                load_req = enable && div_ok;
                idle_req = !enable;
            end
            default: begin
                load_req = 1'b0;
                idle_req = 1'b0;
            end
        endcase
    end

    // Channel FSM with registered clk_out/tick; a load with ratio < 2
    // (possible on sync too) lands in BYPASS so the low phase is never empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            act_div_reg <= '0;
            clk_reg     <= 1'b0;
            tick_reg    <= 1'b0;
        end else begin
            tick_reg <= 1'b0;
            if (load_req) begin
                act_div_reg <= div;
                if (div_ok) begin
                    state_reg <= ST_HIGH;
                    cnt_reg   <= high_last(div);
                    clk_reg   <= 1'b1;
                    tick_reg  <= 1'b1;
                end else begin
                    state_reg <= ST_BYPASS;
                    cnt_reg   <= '0;
                    clk_reg   <= 1'b0;
                end
            end else if (idle_req) begin
                state_reg <= ST_IDLE;
                cnt_reg   <= '0;
                clk_reg   <= 1'b0;
            end else begin
                unique case (state_reg)
                    ST_HIGH: begin
                        if (cnt_reg == '0) begin
                            state_reg <= ST_LOW;
                            cnt_reg   <= low_last(act_div_reg);
                            clk_reg   <= 1'b0;
                        end else begin
                            cnt_reg <= cnt_reg - DIV_W'(1);
                        end
                    end
                    ST_LOW:  cnt_reg <= cnt_reg - DIV_W'(1);
                    default: cnt_reg <= cnt_reg;
                endcase
            end
        end
    end

    assign clk_out = (state_reg == ST_BYPASS) ? clk : clk_reg;
    assign tick    = (state_reg == ST_BYPASS) | tick_reg;
    assign active  = (state_reg != ST_IDLE);

endmodule

// File: rtl/clk_div_multi.sv
// Bank of independent clock divider channels sharing one source clock and
// one phase-alignment strobe.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int DIV_W  = DEF_DIV_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       enable,
    input  logic [NUM_CH*DIV_W-1:0] div,
    input  logic                    sync,
    output logic [NUM_CH-1:0]       clk_out,
    output logic [NUM_CH-1:0]       tick,
    output logic [NUM_CH-1:0]       active
);

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            clk_div_ch #(
                .DIV_W (DIV_W)
            ) u_ch (
                .clk     (clk),
                .rst_n   (rst_n),
                .enable  (enable[gi]),
                .div     (div[gi*DIV_W +: DIV_W]),
                .sync    (sync),
                .clk_out (clk_out[gi]),
                .tick    (tick[gi]),
                .active  (active[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi with a per-cycle reference model that
// tracks each channel as (mode, position in period, ratio).
module tb_clk_div_multi;

    localparam int NUM_CH = 4;
    localparam int DIV_W  = 8;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [NUM_CH-1:0]       enable;
    logic [NUM_CH*DIV_W-1:0] div;
    logic                    sync;
    logic [NUM_CH-1:0]       clk_out;
    logic [NUM_CH-1:0]       tick;
    logic [NUM_CH-1:0]       active;

    int n_chk  = 0;
    int n_fail = 0;

    clk_div_multi #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (enable),
        .div     (div),
        .sync    (sync),
        .clk_out (clk_out),
        .tick    (tick),
        .active  (active)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // mode 0 = off, 1 = dividing, 2 = pass-through
    typedef struct {
        int mode;
        int phase;
        int per;
    } mch_t;

    mch_t mdl [NUM_CH];

    function automatic mch_t start(input int d);
        mch_t n;
        n.mode  = (d >= 2) ? 1 : 2;
        n.phase = 0;
        n.per   = d;
        return n;
    endfunction

    function automatic mch_t step(input mch_t c, input bit en, input int d, input bit s);
        mch_t n = c;
        if (c.mode == 0) begin
            if (en) n = start(d);
        end else if (c.mode == 1) begin
            if (s) n = start(d);
            else if (c.phase == c.per - 1) begin
                if (en) n = start(d);
                else    n.mode = 0;
            end else n.phase = c.phase + 1;
        end else begin
            if (!en)         n.mode = 0;
            else if (d >= 2) n = start(d);
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                mdl[i].mode  <= 0;
                mdl[i].phase <= 0;
                mdl[i].per   <= 0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++)
                mdl[i] <= step(mdl[i], enable[i], int'(div[i*DIV_W +: DIV_W]), sync);
        end
    end

    task automatic check(input string nm, input int ch, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s ch%0d: got %0h expected %0h at %0t", nm, ch, act, exp, $time);
        end
    endtask

    // Per-cycle comparison, taken 3 time units after the rising edge
    // (clk is high here, so a pass-through channel must read 1).
    always @(posedge clk) begin
        #3;
        for (int i = 0; i < NUM_CH; i++) begin
            logic e_clk, e_tick, e_act;
            e_clk  = 1'b0;
            e_tick = 1'b0;
            e_act  = 1'b0;
            if (mdl[i].mode == 1) begin
                e_clk  = (mdl[i].phase < (mdl[i].per + 1) / 2);
                e_tick = (mdl[i].phase == 0);
                e_act  = 1'b1;
            end else if (mdl[i].mode == 2) begin
                e_clk  = clk;
                e_tick = 1'b1;
                e_act  = 1'b1;
            end
            check("cmp_clk_out", i, 32'(clk_out[i]), 32'(e_clk));
            check("cmp_tick",    i, 32'(tick[i]),    32'(e_tick));
            check("cmp_active",  i, 32'(active[i]),  32'(e_act));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic set_div(input int ch, input int d);
        div[ch*DIV_W +: DIV_W] = DIV_W'(d);
    endtask

    // Step n cycles, checking channel ch against hand-written patterns
    // (MSB = first cycle).
    task automatic expect_seq(input string nm, input int ch, input logic [15:0] cp,
                              input logic [15:0] tp, input int n);
        for (int k = 0; k < n; k++) begin
            cyc();
            check({nm, "_clk"},  ch, 32'(clk_out[ch]), 32'(cp[n-1-k]));
            check({nm, "_tick"}, ch, 32'(tick[ch]),    32'(tp[n-1-k]));
        end
    endtask

    initial begin
        int hi;
        int lo;
        rst_n  = 1'b0;
        enable = '0;
        div    = '0;
        sync   = 1'b0;
        repeat (3) cyc();
        check("rst_clk_out", 0, 32'(clk_out), 32'h0);
        check("rst_tick",    0, 32'(tick),    32'h0);
        check("rst_active",  0, 32'(active),  32'h0);
        rst_n = 1'b1;
        cyc();

        // Channel 0: ratio 4, then 5 requested mid-period
        set_div(0, 4);
        enable[0] = 1'b1;
        expect_seq("div4", 0, 16'b110011001, 16'b100010001, 9);
        set_div(0, 5);
        expect_seq("div4to5", 0, 16'b10011100, 16'b00010000, 8);
        enable[0] = 1'b0;
        repeat (6) cyc();
        check("ch0_stopped", 0, 32'(active[0]), 32'h0);

        // Channel 1: pass-through for ratios 1 and 0, then ratio 6
        set_div(1, 1);
        enable[1] = 1'b1;
        cyc();
        check("byp_active", 1, 32'(active[1]),  32'h1);
        check("byp_tick",   1, 32'(tick[1]),    32'h1);
        check("byp_low",    1, 32'(clk_out[1]), 32'h0);
        @(posedge clk);
        #1;
        check("byp_high",   1, 32'(clk_out[1]), 32'h1);
        set_div(1, 0);
        cyc();
        check("byp0_active", 1, 32'(active[1]), 32'h1);
        set_div(1, 6);
        expect_seq("div6", 1, 16'b1110001, 16'b1000001, 7);
        enable[1] = 1'b0;

        // Channel 2: enable dropped one cycle into HIGH
        set_div(2, 8);
        enable[2] = 1'b1;
        expect_seq("stop_a", 2, 16'b11, 16'b10, 2);
        enable[2] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            logic [7:0] act_pat;
            logic [7:0] clk_pat;
            act_pat = 8'b11111100;
            clk_pat = 8'b11000000;
            cyc();
            check("stop_clk",    2, 32'(clk_out[2]), 32'(clk_pat[7-k]));
            check("stop_active", 2, 32'(active[2]),  32'(act_pat[7-k]));
        end

        // sync alignment across all channels with staggered starts
        set_div(0, 3); set_div(1, 4); set_div(2, 6); set_div(3, 7);
        enable = 4'b0001; cyc();
        enable = 4'b0011; repeat (2) cyc();
        enable = 4'b0111; cyc();
        enable = 4'b1111; repeat (10) cyc();
        sync = 1'b1;
        cyc();
        sync = 1'b0;
        check("sync_tick", 0, 32'(tick),    32'hF);
        check("sync_clk",  0, 32'(clk_out), 32'hF);
        cyc();
        check("sync_tick_next", 0, 32'(tick), 32'h0);
        repeat (12) cyc();

        // sync at a period boundary with enable low: sync wins
        enable = '0;
        rst_n  = 1'b0;
        cyc();
        rst_n = 1'b1;
        set_div(0, 4);
        enable[0] = 1'b1;
        repeat (4) cyc();
        enable[0] = 1'b0;
        sync      = 1'b1;
        cyc();
        sync = 1'b0;
        check("syncwin_tick",   0, 32'(tick[0]),    32'h1);
        check("syncwin_clk",    0, 32'(clk_out[0]), 32'h1);
        check("syncwin_active", 0, 32'(active[0]),  32'h1);
        repeat (5) cyc();

        // Reset in the middle of a long high phase, then full 255 period
        set_div(3, 255);
        enable = 4'b1000;
        repeat (5) cyc();
        check("pre_rst_clk", 3, 32'(clk_out[3]), 32'h1);
        rst_n = 1'b0;
        #1;
        check("async_rst_clk",    3, 32'(clk_out[3]), 32'h0);
        check("async_rst_active", 3, 32'(active[3]),  32'h0);
        cyc();
        rst_n = 1'b1;
        cyc();
        hi = 0;
        while (clk_out[3] === 1'b1 && hi < 300) begin
            hi++;
            cyc();
        end
        check("div255_high", 3, 32'(hi), 32'd128);
        lo = 0;
        while (clk_out[3] === 1'b0 && lo < 300) begin
            lo++;
            cyc();
        end
        check("div255_low", 3, 32'(lo), 32'd127);
        enable = '0;
        repeat (3) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
